// File: rtl/dz_pkg.sv
// Shared definitions for the dz_countdown timer: FSM state encoding,
// display row count and the 16-glyph 8x8 hex font.
package dz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } dz_state_e;

  localparam int unsigned DZ_ROWS = 8;

  // One 64-bit bitmap per hex digit; row 0 (top) is the most significant
  // byte, column 0 (left) is bit 7 of each byte.
  localparam logic [63:0] DZ_FONT [16] = '{
    64'h3C666E7666663C00,  // 0
    64'h1838181818187E00,  // 1
    64'h3C66060C30607E00,  // 2
    64'h3C66061C06663C00,  // 3
    64'h0C1C3C6C7E0C0C00,  // 4
    64'h7E607C0606663C00,  // 5
    64'h3C607C6666663C00,  // 6
    64'h7E060C1830303000,  // 7
    64'h3C66663C66663C00,  // 8
    64'h3C66663E060C3800,  // 9
    64'h183C66667E666600,  // A
    64'h7C66667C66667C00,  // B
    64'h3C66606060663C00,  // C
    64'h786C6666666C7800,  // D
    64'h7E60607C60607E00,  // E
    64'h7E60607C60606000   // F
  };

endpackage

// File: rtl/dz_font_rom.sv
// Combinational hex-glyph lookup: 4-bit digit and 3-bit row in,
// 8-bit column pattern out.
module dz_font_rom
  import dz_pkg::*;
(
  input  logic [3:0] glyph_i,
  input  logic [2:0] row_i,
  output logic [7:0] cols_o
);

  logic [63:0] bitmap;
  logic [5:0]  lsb;

  always_comb begin
    bitmap = DZ_FONT[glyph_i];
    lsb    = {3'd7 - row_i, 3'b000};
    cols_o = bitmap[lsb +: 8];
  end

endmodule

// File: rtl/dz_countdown.sv
// Loadable countdown timer with exact-period prescaler and an 8x8 row-scan
// hex display. Define DZ_BLINK_EN to blink the display in PAUSE and DONE.
module dz_countdown
  import dz_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 1000,
  parameter int unsigned CNT_W         = 4,
  parameter int unsigned START_DEFAULT = 5,
  parameter int unsigned SCAN_DIV      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             pause_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tick_o,
  output logic             done_o,
  output logic [7:0]       row_o,
  output logic [7:0]       colr_o,
  output logic [7:0]       colg_o
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0]    SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_RST    = CNT_W'(START_DEFAULT);
  localparam int unsigned      RST_GLYPH  = START_DEFAULT % 16;
  localparam logic [63:0]      RST_BITMAP = DZ_FONT[RST_GLYPH];
  localparam logic [7:0]       RST_COLS   = RST_BITMAP[63:56];

  dz_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] reload_q, reload_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [SW-1:0]    scan_q, scan_d;
  logic [2:0]       row_idx_q, row_idx_d;
  logic             tick_q, tick_d;
  logic             done_q;
  logic [7:0]       row_q, colr_q, colg_q;
  logic [7:0]       colr_d, colg_d;
  logic [7:0]       glyph_cols;
  logic             step;
  logic             blank;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    tick_d   = 1'b0;
    step     = (presc_q == PRESC_LAST);
    if (load_i) begin
      state_d  = ST_IDLE;
      count_d  = load_val_i;
      reload_d = load_val_i;
      presc_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start_i) begin
          presc_d = '0;
          state_d = (count_q != '0) ? ST_RUN : ST_DONE;
        end
        ST_RUN: begin
          // start has no effect while running; the step wins over pause
          presc_d = step ? '0 : presc_q + 1'b1;
          if (step) begin
            tick_d  = 1'b1;
            count_d = count_q - 1'b1;
          end
          if (step && count_q == CNT_W'(1)) state_d = ST_DONE;
          else if (pause_i)                 state_d = ST_PAUSE;
        end
        ST_PAUSE: if (!pause_i) state_d = ST_RUN;
        ST_DONE: if (start_i) begin
          state_d = ST_IDLE;
          count_d = reload_q;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    scan_d    = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
    row_idx_d = (scan_q == SCAN_LAST) ? row_idx_q + 3'd1 : row_idx_q;
  end

  // Columns are looked up from next-state values so they land together with row.
  dz_font_rom u_font (
    .glyph_i (4'(count_d)),
    .row_i   (row_idx_d),
    .cols_o  (glyph_cols)
  );

`ifdef DZ_BLINK_EN
  localparam logic [PW-1:0] BLINK_HALF = PW'(TICK_DIV / 2);
  logic [PW-1:0] blink_q, blink_d;

  always_comb begin
    blink_d = (blink_q == PRESC_LAST) ? '0 : blink_q + 1'b1;
    blank   = (state_d == ST_PAUSE || state_d == ST_DONE) && (blink_d >= BLINK_HALF);
  end

  always_ff @(posedge clk) begin
    if (rst) blink_q <= '0;
    else     blink_q <= blink_d;
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    colr_d = '0;
    colg_d = '0;
    if (!blank) begin
      unique case (state_d)
        ST_IDLE:          begin colr_d = glyph_cols; colg_d = glyph_cols; end
        ST_RUN, ST_PAUSE: colr_d = glyph_cols;
        ST_DONE:          colg_d = glyph_cols;
        default:          colr_d = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= CNT_RST;
      reload_q  <= CNT_RST;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      scan_q    <= '0;
      row_idx_q <= 3'd0;
      row_q     <= 8'b0000_0001;
      colr_q    <= RST_COLS;
      colg_q    <= RST_COLS;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      presc_q   <= presc_d;
      tick_q    <= tick_d;
      done_q    <= (state_d == ST_DONE);
      scan_q    <= scan_d;
      row_idx_q <= row_idx_d;
      row_q     <= 8'b0000_0001 << row_idx_d;
      colr_q    <= colr_d;
      colg_q    <= colg_d;
    end
  end

  assign count_o = count_q;
  assign tick_o  = tick_q;
  assign done_o  = done_q;
  assign row_o   = row_q;
  assign colr_o  = colr_q;
  assign colg_o  = colg_q;

endmodule

// File: tb/tb_dz_countdown.sv
// Self-checking bench for dz_countdown: directed scenarios plus random
// stimulus, all compared every cycle against a behavioural timer model.
module tb_dz_countdown;

  localparam int TD  = 4;
  localparam int CW  = 4;
  localparam int SD  = 5;
  localparam int SCD = 1;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst, start, pause, load;
  logic [CW-1:0] load_val;
  logic [CW-1:0] count;
  logic          tick, done;
  logic [7:0]    row, colr, colg;

  logic [3:0] fr_g;
  logic [2:0] fr_r;
  logic [7:0] fr_cols;

  always #5 clk = ~clk;

  dz_countdown #(
    .TICK_DIV(TD), .CNT_W(CW), .START_DEFAULT(SD), .SCAN_DIV(SCD)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start), .pause_i(pause), .load_i(load),
    .load_val_i(load_val), .count_o(count), .tick_o(tick), .done_o(done),
    .row_o(row), .colr_o(colr), .colg_o(colg)
  );

  dz_font_rom u_rom_chk (.glyph_i(fr_g), .row_i(fr_r), .cols_o(fr_cols));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] glyph_row(input int g, input int r);
    logic [63:0] bm;
    case (g)
      0:  bm = 64'h3C666E7666663C00;  1:  bm = 64'h1838181818187E00;
      2:  bm = 64'h3C66060C30607E00;  3:  bm = 64'h3C66061C06663C00;
      4:  bm = 64'h0C1C3C6C7E0C0C00;  5:  bm = 64'h7E607C0606663C00;
      6:  bm = 64'h3C607C6666663C00;  7:  bm = 64'h7E060C1830303000;
      8:  bm = 64'h3C66663C66663C00;  9:  bm = 64'h3C66663E060C3800;
      10: bm = 64'h183C66667E666600;  11: bm = 64'h7C66667C66667C00;
      12: bm = 64'h3C66606060663C00;  13: bm = 64'h786C6666666C7800;
      14: bm = 64'h7E60607C60607E00;  default: bm = 64'h7E60607C60606000;
    endcase
    return bm[63 - 8 * r -: 8];
  endfunction

  // Reference model: the timer as a mode plus a phase within the tick period.
  int m_mode, m_count, m_reload, m_phase, m_tick, m_row, m_scan, m_blink;

  task automatic model_reset();
    m_mode = M_IDLE; m_count = SD; m_reload = SD; m_phase = 0;
    m_tick = 0; m_row = 0; m_scan = 0; m_blink = 0;
  endtask

  task automatic model_step(input logic r, input logic s, input logic p,
                            input logic l, input int v);
    if (r) begin
      model_reset();
    end else begin
      m_tick = 0;
      if (m_scan == SCD - 1) begin m_scan = 0; m_row = (m_row + 1) % 8; end
      else m_scan++;
      m_blink = (m_blink + 1) % TD;
      if (l) begin
        m_mode = M_IDLE; m_count = v; m_reload = v; m_phase = 0;
      end else begin
        case (m_mode)
          M_IDLE: if (s) begin
            m_phase = 0;
            m_mode  = (m_count != 0) ? M_RUN : M_DONE;
          end
          M_RUN: begin
            if (m_phase == TD - 1) begin m_phase = 0; m_count--; m_tick = 1; end
            else m_phase++;
            if (m_count == 0) m_mode = M_DONE;
            else if (p)       m_mode = M_PAUSE;
          end
          M_PAUSE: if (!p) m_mode = M_RUN;
          default: if (s) begin m_mode = M_IDLE; m_count = m_reload; end
        endcase
      end
    end
  endtask

  task automatic compare_all();
    logic [7:0] g, er, eg;
    logic       blank;
    g = glyph_row(m_count % 16, m_row);
    blank = 1'b0;
`ifdef DZ_BLINK_EN
    blank = (m_mode == M_PAUSE || m_mode == M_DONE) && (m_blink >= TD / 2);
`endif
    er = 8'h00; eg = 8'h00;
    if (!blank) begin
      if (m_mode == M_IDLE)                           begin er = g; eg = g; end
      else if (m_mode == M_RUN || m_mode == M_PAUSE)  er = g;
      else                                            eg = g;
    end
    check("count", 32'(count), 32'(m_count));
    check("tick",  32'(tick),  32'(m_tick));
    check("done",  32'(done),  32'(m_mode == M_DONE));
    check("row",   32'(row),   32'(8'h01 << m_row));
    check("colr",  32'(colr),  32'(er));
    check("colg",  32'(colg),  32'(eg));
  endtask

  task automatic cycle(input logic r, input logic s, input logic p,
                       input logic l, input logic [CW-1:0] v);
    rst = r; start = s; pause = p; load = l; load_val = v;
    @(posedge clk);
    model_step(r, s, p, l, int'(v));
    #1;
    compare_all();
  endtask

  task automatic idle_cycles(input int n, input logic p);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, p, 1'b0, '0);
  endtask

  // Standalone font lookup against the bench's own glyph table.
  initial begin
    for (int g = 0; g < 16; g++)
      for (int r = 0; r < 8; r++) begin
        fr_g = 4'(g); fr_r = 3'(r);
        #1;
        check("rom", 32'(fr_cols), 32'(glyph_row(g, r)));
      end
  end

  initial begin
    logic p_lvl;
    model_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("rst_count", 32'(count), 32'd5);
    check("rst_tick",  32'(tick),  32'd0);
    check("rst_row",   32'(row),   32'h01);
    check("rst_colr",  32'(colr),  32'h7E);
    check("rst_colg",  32'(colg),  32'h7E);

    // Plain countdown from the reset value.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
      check("s1_tick",  32'(tick),  32'(i % 4 == 0));
      check("s1_count", 32'(count), 32'(5 - i / 4));
    end
    check("s1_done", 32'(done), 32'd1);
    check("s1_colr", 32'(colr), 32'd0);

    // Load 9 and count down to zero, then restart to the reload value.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd9);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle_cycles(35, 1'b0);
    check("s2_not_yet", 32'(done), 32'd0);
    idle_cycles(1, 1'b0);
    check("s2_count", 32'(count), 32'd0);
    check("s2_done",  32'(done),  32'd1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("s2_reload", 32'(count), 32'd9);

    // Pause two cycles into a period for ten cycles.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle_cycles(2, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
      check("pause_count", 32'(count), 32'd9);
      check("pause_tick",  32'(tick),  32'd0);
    end
    idle_cycles(1, 1'b0);
    check("resume_tick0", 32'(tick), 32'd0);
    idle_cycles(1, 1'b0);
    check("resume_tick1", 32'(tick),  32'd1);
    check("resume_count", 32'(count), 32'd8);

    // Load beats start while running; zero load then start goes straight to DONE.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
    check("ld_win_count", 32'(count), 32'd7);
    idle_cycles(5, 1'b0);
    check("ld_win_idle", 32'(count), 32'd7);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_tick", 32'(tick), 32'd0);
    idle_cycles(8, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Every glyph across every row in IDLE colour.
    for (int g = 0; g < 16; g++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'(g));
      idle_cycles(8, 1'b0);
    end

    // Reset while running at count 3.
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    idle_cycles(8, 1'b0);
    check("mid_count3", 32'(count), 32'd3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("mid_rst_count", 32'(count), 32'd5);
    check("mid_rst_tick",  32'(tick),  32'd0);
    check("mid_rst_row",   32'(row),   32'h01);
    check("mid_rst_done",  32'(done),  32'd0);

    // Random traffic.
    p_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) p_lvl = ~p_lvl;
      cycle($urandom_range(299) == 0, $urandom_range(7) == 0, p_lvl,
            $urandom_range(39) == 0, 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
